pc_sequencer: RTL and testbench

- Owns the architectural PC register and the N/Z/V flag register, and sequences instruction commit for the single-cycle core.
- Drives the PC and flags into the next-PC calculation unit (PC+2 / branch target selection) and accepts that unit's result as PC_next.
- Gates each commit on an instruction-fetch handshake and an external stall.
- Handles HLT by freezing the machine until reset.

---
 rtl/pc_sequencer.sv | 89 ++++++++
 tb/tb_pc_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// PC / N-Z-V flag owner and instruction commit sequencer for the single-cycle core.
// Optional retire counter output (retire_count) enabled by defining PC_RETIRE_CNT_EN.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [2:0]  FLAG_RESET = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC_next,
  input  logic        hlt,
  input  logic [2:0]  flag_we,
  input  logic [2:0]  flags_in,
  input  logic        fetch_ready,
  input  logic        stall_req,
  output logic [15:0] PC,
  output logic        fetch_req,
  output logic [2:0]  flags,
  output logic        retire,
  output logic        halted
`ifdef PC_RETIRE_CNT_EN
  ,
  output logic [15:0] retire_count
`endif
);

  typedef enum logic [1:0] {StBoot, StFetch, StStall, StHalt} state_e;

  state_e      state;
  logic        commit;
  logic [15:0] pc_target;
  logic [2:0]  flags_merged;

  // A commit happens on the edge that leaves FETCH (fetch done, no stall) or STALL (stall dropped).
  assign commit       = !stall_req && ((state == StFetch && fetch_ready) || state == StStall);
  assign pc_target    = {PC_next[15:1], 1'b0};
  assign flags_merged = (flags & ~flag_we) | (flags_in & flag_we);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StBoot;
      PC        <= RESET_PC;
      flags     <= FLAG_RESET;
      fetch_req <= 1'b0;
      retire    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      retire <= 1'b0;
      unique case (state)
        StBoot: begin
          state     <= StFetch;
          fetch_req <= 1'b1;
        end
        StFetch: begin
          if (fetch_ready && stall_req) begin
            state     <= StStall;
            fetch_req <= 1'b0;
          end
        end
        StStall: ;
        StHalt:  ;
      endcase
      if (commit) begin
        retire <= 1'b1;
        if (hlt) begin
          state     <= StHalt;
          fetch_req <= 1'b0;
          halted    <= 1'b1;
        end else begin
          state     <= StFetch;
          fetch_req <= 1'b1;
          PC        <= pc_target;
          flags     <= flags_merged;
        end
      end
    end
  end

`ifdef PC_RETIRE_CNT_EN
  // Counts at the commit edge so the count already includes the retire being pulsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_count <= 16'h0000;
    end else if (commit) begin
      retire_count <= retire_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: commit timing, stall, flags, halt, wrap, reset.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] PC_next;
  logic        hlt;
  logic [2:0]  flag_we;
  logic [2:0]  flags_in;
  logic        fetch_ready;
  logic        stall_req;
  logic [15:0] PC;
  logic        fetch_req;
  logic [2:0]  flags;
  logic        retire;
  logic        halted;
`ifdef PC_RETIRE_CNT_EN
  logic [15:0] retire_count;
`endif

  int checks   = 0;
  int failures = 0;

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .PC_next     (PC_next),
    .hlt         (hlt),
    .flag_we     (flag_we),
    .flags_in    (flags_in),
    .fetch_ready (fetch_ready),
    .stall_req   (stall_req),
    .PC          (PC),
    .fetch_req   (fetch_req),
    .flags       (flags),
    .retire      (retire),
    .halted      (halted)
`ifdef PC_RETIRE_CNT_EN
    ,
    .retire_count(retire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks PC, flags, fetch_req, retire, halted in one go.
  task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic [2:0] e_flags,
                         input logic e_freq, input logic e_ret, input logic e_halt);
    chk({tag, ".pc"}, PC, e_pc);
    chk({tag, ".flags"}, {13'd0, flags}, {13'd0, e_flags});
    chk({tag, ".fetch_req"}, {15'd0, fetch_req}, {15'd0, e_freq});
    chk({tag, ".retire"}, {15'd0, retire}, {15'd0, e_ret});
    chk({tag, ".halted"}, {15'd0, halted}, {15'd0, e_halt});
  endtask

  initial begin
    rst = 1'b1; PC_next = 16'h0000; hlt = 1'b0; flag_we = 3'b000; flags_in = 3'b000;
    fetch_ready = 1'b0; stall_req = 1'b0;
    tick(); tick();
    chk_all("reset", 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
`ifdef PC_RETIRE_CNT_EN
    chk("reset.count", retire_count, 16'd0);
`endif

    // Back-to-back commits with PC_next = PC + 2.
    rst = 1'b0; fetch_ready = 1'b1; PC_next = 16'h0002;
    tick(); chk_all("boot", 16'h0000, 3'b000, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("seq1", 16'h0002, 3'b000, 1'b1, 1'b1, 1'b0);
    PC_next = 16'h0004;
    tick(); chk_all("seq2", 16'h0004, 3'b000, 1'b1, 1'b1, 1'b0);
    PC_next = 16'h0010;
    tick(); chk_all("seq3", 16'h0010, 3'b000, 1'b1, 1'b1, 1'b0);

    // fetch_ready low for three cycles.
    fetch_ready = 1'b0; PC_next = 16'h0012;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("wait", 16'h0010, 3'b000, 1'b1, 1'b0, 1'b0);
    end
    fetch_ready = 1'b1; flag_we = 3'b111; flags_in = 3'b101;
    tick(); chk_all("wait_done", 16'h0012, 3'b101, 1'b1, 1'b1, 1'b0);

    // Stall four cycles while only Z is written.
    stall_req = 1'b1; flag_we = 3'b010; flags_in = 3'b010; PC_next = 16'h0014;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_all("stall", 16'h0012, 3'b101, 1'b0, 1'b0, 1'b0);
    end
    stall_req = 1'b0;
    tick(); chk_all("stall_done", 16'h0014, 3'b111, 1'b1, 1'b1, 1'b0);
    flag_we = 3'b000; fetch_ready = 1'b0;
    tick(); chk_all("single_retire", 16'h0014, 3'b111, 1'b1, 1'b0, 1'b0);

    // Wrap-around and bit0 forced low; clear only V.
    fetch_ready = 1'b1; PC_next = 16'hFFFE;
    tick(); chk("wrap_pre", PC, 16'hFFFE);
    PC_next = 16'h0000;
    tick(); chk("wrap", PC, 16'h0000);
    PC_next = 16'h0035; flag_we = 3'b001; flags_in = 3'b000;
    tick(); chk_all("odd", 16'h0034, 3'b110, 1'b1, 1'b1, 1'b0);
    flag_we = 3'b000; PC_next = 16'h0020;
    tick(); chk("pre_hlt", PC, 16'h0020);

    // HLT commit: PC and flags frozen, inputs ignored afterwards.
    hlt = 1'b1; PC_next = 16'h0022; flag_we = 3'b111; flags_in = 3'b000;
    tick(); chk_all("hlt", 16'h0020, 3'b110, 1'b0, 1'b1, 1'b1);
`ifdef PC_RETIRE_CNT_EN
    chk("hlt.count", retire_count, 16'd10);
`endif
    hlt = 1'b0; PC_next = 16'h0040; stall_req = 1'b1;
    tick(); chk_all("halt1", 16'h0020, 3'b110, 1'b0, 1'b0, 1'b1);
    stall_req = 1'b0;
    tick(); chk_all("halt2", 16'h0020, 3'b110, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset out of HALT.
    #3 rst = 1'b1;
    #1 chk_all("halt_rst", 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();

    // hlt together with stall: STALL first, then halt commit.
    rst = 1'b0; fetch_ready = 1'b1; PC_next = 16'h0050;
    tick(); chk("boot2.fetch_req", {15'd0, fetch_req}, 16'd1);
    hlt = 1'b1; stall_req = 1'b1;
    tick(); chk_all("hs_stall", 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
    stall_req = 1'b0;
    tick(); chk_all("hs_halt", 16'h0000, 3'b000, 1'b0, 1'b1, 1'b1);
    hlt = 1'b0;

    // Reset mid-STALL abandons the instruction.
    rst = 1'b1;
    tick();
    rst = 1'b0; PC_next = 16'h0008; flag_we = 3'b111; flags_in = 3'b111;
    tick();
    tick(); chk_all("pre_stall", 16'h0008, 3'b111, 1'b1, 1'b1, 1'b0);
    stall_req = 1'b1; PC_next = 16'h000A; flags_in = 3'b000;
    tick(); tick(); chk_all("mid_stall", 16'h0008, 3'b111, 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1 chk_all("stall_rst", 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
`ifdef PC_RETIRE_CNT_EN
    chk("stall_rst.count", retire_count, 16'd0);
`endif
    stall_req = 1'b0;
    tick(); chk_all("stall_rst_hold", 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
